// File: rtl/load_store_sequencer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : load_store_sequencer_if
// Description : Request, data-memory bus and response signals of the
//               load/store sequencer. The master view belongs to the
//               sequencer (it masters the memory bus and answers requests);
//               the slave view belongs to the surrounding execute stage and
//               memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_sequencer_if;
    // request from the AGU / execute stage
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [31:0] req_address;
    logic [31:0] req_store_data;
    // data-memory bus
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    // response
    logic        rsp_valid;
    logic [31:0] rsp_load_data;
    logic        rsp_error;

    modport master (
        input  req_valid, req_opcode, req_funct3, req_address, req_store_data,
        output req_ready,
        output mem_valid, mem_write, mem_address, mem_byte_enable, mem_write_data,
        input  mem_ready, mem_read_data,
        output rsp_valid, rsp_load_data, rsp_error
    );

    modport slave (
        output req_valid, req_opcode, req_funct3, req_address, req_store_data,
        input  req_ready,
        input  mem_valid, mem_write, mem_address, mem_byte_enable, mem_write_data,
        output mem_ready, mem_read_data,
        input  rsp_valid, rsp_load_data, rsp_error
    );
endinterface
`default_nettype wire

// File: rtl/load_store_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : load_store_sequencer
// Description : Runs one LOAD/STORE request as one or two word-aligned
//               data-memory transactions. Stores are lane-shifted with byte
//               enables; loads are merged, extracted and sign/zero extended.
//               Word-crossing accesses are split or flagged as errors
//               depending on ALLOW_MISALIGNED.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_sequencer #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    load_store_sequencer_if.master bus
);

    localparam logic [6:0] C_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS_0 = 2'd1,
        S_ACCESS_1 = 2'd2,
        S_RESPOND  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // request fields captured at accept
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic        r_split;
    logic        r_error;
    // read words from the first and second transaction
    logic [31:0] r_rd0;
    logic [31:0] r_rd1;

    logic        w_ready;
    logic        w_accept;
    logic        w_legal;
    logic        w_req_split;
    logic        w_req_error;
    logic [7:0]  w_mask8;
    logic [63:0] w_wide;
    logic [31:0] w_base;
    logic [31:0] w_word;
    logic [31:0] w_load;

    // access size in bytes from funct3[1:0]; the illegal 11 code maps to 4
    // but is rejected by the legality check anyway
    function automatic logic [2:0] f_size(input logic [1:0] f);
        case (f)
            2'b00:   f_size = 3'd1;
            2'b01:   f_size = 3'd2;
            default: f_size = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] f_mask(input logic [1:0] f);
        case (f)
            2'b00:   f_mask = 4'b0001;
            2'b01:   f_mask = 4'b0011;
            default: f_mask = 4'b1111;
        endcase
    endfunction

    // ready only when idle and out of reset
    assign w_ready       = (r_state == S_IDLE) && !reset;
    assign w_accept      = bus.req_valid && w_ready;
    assign bus.req_ready = w_ready;

    // legality of the incoming opcode/funct3 pair
    always_comb begin
        w_legal = 1'b0;
        if (bus.req_opcode == C_OPC_LOAD) begin
            w_legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end else if (bus.req_opcode == C_OPC_STORE) begin
            w_legal = (bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
        end
    end

    assign w_req_split = ({1'b0, bus.req_address[1:0]} + f_size(bus.req_funct3[1:0])) > 3'd4;
    assign w_req_error = !w_legal || (w_req_split && !ALLOW_MISALIGNED);

    // lane placement derived from the captured request
    assign w_mask8 = {4'b0000, f_mask(r_funct3[1:0])} << r_addr[1:0];
    assign w_wide  = {32'd0, r_sdata} << {r_addr[1:0], 3'b000};
    assign w_base  = {r_addr[31:2], 2'b00};
    assign w_word  = 32'({r_rd1, r_rd0} >> {r_addr[1:0], 3'b000});

    // sub-word extension of the extracted load value
    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_word[7]}}, w_word[7:0]};
            3'b001:  w_load = {{16{w_word[15]}}, w_word[15:0]};
            3'b100:  w_load = {24'd0, w_word[7:0]};
            3'b101:  w_load = {16'd0, w_word[15:0]};
            default: w_load = w_word;
        endcase
    end

    // state register, request capture and read-word capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_sdata  <= 32'd0;
            r_split  <= 1'b0;
            r_error  <= 1'b0;
            r_rd0    <= 32'd0;
            r_rd1    <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_store  <= (bus.req_opcode == C_OPC_STORE);
                r_funct3 <= bus.req_funct3;
                r_addr   <= bus.req_address;
                r_sdata  <= bus.req_store_data;
                r_split  <= w_req_split;
                r_error  <= w_req_error;
                r_rd0    <= 32'd0;
                r_rd1    <= 32'd0;  // unsplit loads merge against zero
            end
            if (r_state == S_ACCESS_0 && bus.mem_ready) begin
                r_rd0 <= bus.mem_read_data;
            end
            if (r_state == S_ACCESS_1 && bus.mem_ready) begin
                r_rd1 <= bus.mem_read_data;
            end
        end
    end

    // next-state and bus/response outputs; all outputs idle at zero
    always_comb begin
        w_next              = r_state;
        bus.mem_valid       = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 32'd0;
        bus.mem_byte_enable = 4'd0;
        bus.mem_write_data  = 32'd0;
        bus.rsp_valid       = 1'b0;
        bus.rsp_load_data   = 32'd0;
        bus.rsp_error       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_req_error ? S_RESPOND : S_ACCESS_0;
                end
            end
            S_ACCESS_0: begin
                bus.mem_valid       = 1'b1;
                bus.mem_write       = r_store;
                bus.mem_address     = w_base;
                bus.mem_byte_enable = w_mask8[3:0];
                bus.mem_write_data  = w_wide[31:0];
                if (bus.mem_ready) begin
                    w_next = r_split ? S_ACCESS_1 : S_RESPOND;
                end
            end
            S_ACCESS_1: begin
                bus.mem_valid       = 1'b1;
                bus.mem_write       = r_store;
                bus.mem_address     = w_base + 32'd4;  // wraps past the top of memory
                bus.mem_byte_enable = w_mask8[7:4];
                bus.mem_write_data  = w_wide[63:32];
                if (bus.mem_ready) begin
                    w_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                bus.rsp_valid     = 1'b1;
                bus.rsp_error     = r_error;
                bus.rsp_load_data = (r_store || r_error) ? 32'd0 : w_load;
                w_next            = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_load_store_sequencer
// Description : Scoreboard bench for load_store_sequencer. Directed requests
//               push expected bus transactions and responses into queues; a
//               bus responder and a response monitor pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_sequencer;

    localparam logic [6:0] C_LOAD  = 7'b0000011;
    localparam logic [6:0] C_STORE = 7'b0100011;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          waits;
    } bus_tx_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   compared   = 0;
    int   mismatched = 0;

    bus_tx_t bus_q[$];
    rsp_t    rsp_q[$];
    rsp_t    rsp_q2[$];

    load_store_sequencer_if mif ();
    load_store_sequencer_if mif2 ();

    load_store_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.master)
    );

    load_store_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (mif2.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic wr, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits);
        bus_tx_t t;
        t.wr = wr; t.addr = a; t.be = be; t.wd = wd; t.rdata = rd; t.waits = waits;
        bus_q.push_back(t);
    endtask

    // present one request to the chosen DUT; expected response timed from the accept cycle
    task automatic issue(input bit which, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_data, input bit exp_err, input int lat,
                         input bit expect_rsp);
        rsp_t r;
        int   n;
        @(negedge clk);
        mif.req_opcode  = opc;  mif2.req_opcode  = opc;
        mif.req_funct3  = f3;   mif2.req_funct3  = f3;
        mif.req_address = a;    mif2.req_address = a;
        mif.req_store_data = d; mif2.req_store_data = d;
        if (which) mif2.req_valid = 1'b1; else mif.req_valid = 1'b1;
        n = 0;
        while (!(which ? mif2.req_ready : mif.req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            compared++; mismatched++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
        end
        if (expect_rsp) begin
            r.data = exp_data; r.err = exp_err; r.cyc = cyc + lat;
            if (which) rsp_q2.push_back(r); else rsp_q.push_back(r);
        end
        @(negedge clk);
        mif.req_valid  = 1'b0;
        mif2.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || rsp_q2.size() != 0 || bus_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     rsp_q.size() + rsp_q2.size() + bus_q.size());
            rsp_q.delete(); rsp_q2.delete(); bus_q.delete();
        end
    endtask

    // memory responder: pops the expected transaction, checks it every cycle it is held
    initial begin : responder
        bus_tx_t t;
        int      w;
        bit      busy;
        busy = 1'b0;
        w = 0;
        mif.mem_ready     = 1'b0;
        mif.mem_read_data = 32'd0;
        forever begin
            @(negedge clk);
            if (busy && (mif.mem_ready || !mif.mem_valid)) begin
                busy = 1'b0;
                mif.mem_ready = 1'b0;
            end
            if (mif.mem_valid) begin
                if (!busy) begin
                    if (bus_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_bus_tx: got addr 0x%08h expected no transaction",
                                 mif.mem_address);
                        t.wr = mif.mem_write; t.addr = mif.mem_address; t.be = mif.mem_byte_enable;
                        t.wd = mif.mem_write_data; t.rdata = 32'd0; t.waits = 0;
                    end else begin
                        t = bus_q.pop_front();
                    end
                    w = t.waits;
                    busy = 1'b1;
                end
                check("mem_write",       {31'd0, mif.mem_write},       {31'd0, t.wr});
                check("mem_address",     mif.mem_address,              t.addr);
                check("mem_byte_enable", {28'd0, mif.mem_byte_enable}, {28'd0, t.be});
                check("mem_write_data",  mif.mem_write_data,           t.wd);
                if (w == 0) begin
                    mif.mem_ready     = 1'b1;
                    mif.mem_read_data = t.rdata;
                end else begin
                    w--;
                    mif.mem_ready     = 1'b0;
                    mif.mem_read_data = 32'h0BAD0BAD;
                end
            end
        end
    end

    // response monitor for the splitting instance
    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (mif.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_rsp: got data 0x%08h expected no response",
                             mif.rsp_load_data);
                end else begin
                    e = rsp_q.pop_front();
                    check("rsp_load_data", mif.rsp_load_data,          e.data);
                    check("rsp_error",     {31'd0, mif.rsp_error},     {31'd0, e.err});
                    check("rsp_cycle",     cyc,                        e.cyc);
                end
            end
        end
    end

    // response monitor for the non-splitting instance; it must never touch the bus
    initial begin : rsp_monitor2
        rsp_t e;
        forever begin
            @(negedge clk);
            if (mif2.mem_valid) begin
                compared++; mismatched++;
                $display("FAIL dut2_mem_valid: got 1 expected 0");
            end
            if (mif2.rsp_valid) begin
                if (rsp_q2.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL dut2_unexpected_rsp: got data 0x%08h expected no response",
                             mif2.rsp_load_data);
                end else begin
                    e = rsp_q2.pop_front();
                    check("dut2_rsp_load_data", mif2.rsp_load_data,      e.data);
                    check("dut2_rsp_error",     {31'd0, mif2.rsp_error}, {31'd0, e.err});
                    check("dut2_rsp_cycle",     cyc,                     e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // directed stimulus
    initial begin : stimulus
        int n;
        mif.req_valid = 1'b0;  mif2.req_valid = 1'b0;
        mif.req_opcode = 7'd0; mif2.req_opcode = 7'd0;
        mif.req_funct3 = 3'd0; mif2.req_funct3 = 3'd0;
        mif.req_address = 32'd0; mif2.req_address = 32'd0;
        mif.req_store_data = 32'd0; mif2.req_store_data = 32'd0;
        mif2.mem_ready = 1'b0; mif2.mem_read_data = 32'd0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_req_ready",       {31'd0, mif.req_ready},       32'd0);
        check("reset_mem_valid",       {31'd0, mif.mem_valid},       32'd0);
        check("reset_mem_write",       {31'd0, mif.mem_write},       32'd0);
        check("reset_mem_address",     mif.mem_address,              32'd0);
        check("reset_mem_byte_enable", {28'd0, mif.mem_byte_enable}, 32'd0);
        check("reset_mem_write_data",  mif.mem_write_data,           32'd0);
        check("reset_rsp_valid",       {31'd0, mif.rsp_valid},       32'd0);
        check("reset_rsp_load_data",   mif.rsp_load_data,            32'd0);
        check("reset_rsp_error",       {31'd0, mif.rsp_error},       32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready",  {31'd0, mif.req_ready},       32'd1);

        // LW aligned
        push_tx(1'b0, 32'h00000100, 4'b1111, 32'h0, 32'hDEADBEEF, 0);
        issue(1'b0, C_LOAD, 3'b010, 32'h00000100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        drain();
        // LB / LBU top byte
        push_tx(1'b0, 32'h00000100, 4'b1000, 32'h0, 32'h80123456, 0);
        issue(1'b0, C_LOAD, 3'b000, 32'h00000103, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
        drain();
        push_tx(1'b0, 32'h00000100, 4'b1000, 32'h0, 32'h80123456, 0);
        issue(1'b0, C_LOAD, 3'b100, 32'h00000103, 32'h0, 32'h00000080, 1'b0, 2, 1'b1);
        drain();
        // SW crossing a word boundary
        push_tx(1'b1, 32'h00000200, 4'b1100, 32'h33440000, 32'hFFFFFFFF, 0);
        push_tx(1'b1, 32'h00000204, 4'b0011, 32'h00001122, 32'hFFFFFFFF, 0);
        issue(1'b0, C_STORE, 3'b010, 32'h00000202, 32'h11223344, 32'h0, 1'b0, 3, 1'b1);
        drain();
        // LW wrapping past the top of memory
        push_tx(1'b0, 32'hFFFFFFFC, 4'b1100, 32'h0, 32'hAABB1234, 0);
        push_tx(1'b0, 32'h00000000, 4'b0011, 32'h0, 32'h5678CCDD, 0);
        issue(1'b0, C_LOAD, 3'b010, 32'hFFFFFFFE, 32'h0, 32'hCCDDAABB, 1'b0, 3, 1'b1);
        drain();
        // LH with three bus wait cycles
        push_tx(1'b0, 32'h00000100, 4'b1100, 32'h0, 32'h80010000, 3);
        issue(1'b0, C_LOAD, 3'b001, 32'h00000102, 32'h0, 32'hFFFF8001, 1'b0, 5, 1'b1);
        drain();
        // LHU / LH in the middle lanes
        push_tx(1'b0, 32'h00000040, 4'b0110, 32'h0, 32'h12F00D34, 0);
        issue(1'b0, C_LOAD, 3'b101, 32'h00000041, 32'h0, 32'h0000F00D, 1'b0, 2, 1'b1);
        drain();
        push_tx(1'b0, 32'h00000040, 4'b0110, 32'h0, 32'h12F00D34, 0);
        issue(1'b0, C_LOAD, 3'b001, 32'h00000041, 32'h0, 32'hFFFFF00D, 1'b0, 2, 1'b1);
        drain();
        // SB lane 1; upper store-data bits shift through unmasked
        push_tx(1'b1, 32'h00000000, 4'b0010, 32'hFFFFA500, 32'h0, 0);
        issue(1'b0, C_STORE, 3'b000, 32'h00000001, 32'hFFFFFFA5, 32'h0, 1'b0, 2, 1'b1);
        drain();
        // SH split across lane 3 / next lane 0, second transaction with one wait
        push_tx(1'b1, 32'h00000000, 4'b1000, 32'hEF000000, 32'h0, 0);
        push_tx(1'b1, 32'h00000004, 4'b0001, 32'h000000BE, 32'h0, 1);
        issue(1'b0, C_STORE, 3'b001, 32'h00000003, 32'h0000BEEF, 32'h0, 1'b0, 4, 1'b1);
        drain();
        // illegal requests: no bus activity, error response one cycle after accept
        issue(1'b0, 7'b0110011, 3'b010, 32'h00000100, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        drain();
        issue(1'b0, C_LOAD, 3'b011, 32'h00000100, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        drain();
        issue(1'b0, C_STORE, 3'b100, 32'h00000100, 32'h12345678, 32'h0, 1'b1, 1, 1'b1);
        drain();
        // misaligned with splitting disabled
        issue(1'b1, C_LOAD, 3'b001, 32'h000001FF, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        drain();

        // reset while the second transaction is waiting on the bus
        push_tx(1'b0, 32'h00000004, 4'b1100, 32'h0, 32'h11111111, 0);
        push_tx(1'b0, 32'h00000008, 4'b0011, 32'h0, 32'h22222222, 20);
        issue(1'b0, C_LOAD, 3'b010, 32'h00000006, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        n = 0;
        while (!(mif.mem_valid && mif.mem_address == 32'h00000008) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reach_access_1", {31'd0, mif.mem_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_mem_valid", {31'd0, mif.mem_valid}, 32'd0);
        check("midreset_req_ready", {31'd0, mif.req_ready}, 32'd0);
        check("midreset_rsp_valid", {31'd0, mif.rsp_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("after_midreset_req_ready", {31'd0, mif.req_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("abandoned_tx_queue", bus_q.size(), 32'd0);

        // recovery after the abandoned access
        push_tx(1'b0, 32'h00000010, 4'b1111, 32'h0, 32'h01020304, 0);
        issue(1'b0, C_LOAD, 3'b010, 32'h00000010, 32'h0, 32'h01020304, 1'b0, 2, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
